rx_fifo_buffer: RTL
===================

# rx_fifo_buffer

Receive-side FIFO for the UART receive path. It buffers 12-bit frame records produced by the receive deserializer: 8 data bits, 1 parity bit and 3 error flags. It presents them in arrival order to the receive-stage consumer, which reads on its `receive` order and gates on `RxFE`. The block provides full, empty and occupancy status and a sticky overrun indication for dropped frames.

## Interface
Parameters:
- `DATA_WIDTH`, 12, record width; layout `[7:0]` data, `[8]` parity bit, `[9]` parity error, `[10]` framing error, `[11]` break.
- `DEPTH`, 16, number of entries; must be a power of two, ≥ 2.
- `ADDR_WIDTH`, 4, log2(`DEPTH`).

Ports:
- `baud_clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wr_en` input 1: write request from the deserializer, one cycle per completed frame.
- `data_in` input `DATA_WIDTH`: record to store; sampled when `wr_en`=1.
- `receive` input 1: read order from the downstream consumer.
- `clear_ovr` input 1: clears `overrun`.
- `data_out` output `DATA_WIDTH`: registered read data.
- `RxFE` output 1: FIFO empty (count == 0).
- `RxFF` output 1: FIFO full (count == `DEPTH`).
- `count` output `ADDR_WIDTH+1`: current occupancy, 0..`DEPTH`.
- `overrun` output 1: sticky; at least one write was dropped.

## Operation
- Storage: `DEPTH` × `DATA_WIDTH` register array, with write pointer `wr_ptr`, read pointer `rd_ptr` (both `ADDR_WIDTH` bits) and occupancy counter `count`. The array is not reset.
- Pointers wrap naturally from `DEPTH-1` to 0 through modulo-2^`ADDR_WIDTH` arithmetic. `count` is the sole full/empty discriminator.
- Read accepted (`rd_ok`) = `receive` & (count != 0).
  - Effect: `data_out` <= mem[`rd_ptr`] and `rd_ptr` <= `rd_ptr`+1.
  - If `receive` arrives while empty, it is ignored: `data_out` holds its last value and no state changes.
- Write accepted (`wr_ok`) = `wr_en` & ((count != `DEPTH`) | `rd_ok`).
  - Effect: mem[`wr_ptr`] <= `data_in` and `wr_ptr` <= `wr_ptr`+1.
  - A write while full with a simultaneous accepted read succeeds; the freed slot is reused.
- Dropped write: `wr_en` while full with no accepted read. `data_in` is discarded, `overrun` <= 1 and the FIFO contents are untouched.
- Count update:
  - `wr_ok` & !`rd_ok`: +1.
  - `rd_ok` & !`wr_ok`: −1.
  - both or neither: unchanged.
- Simultaneous read and write while empty: the read is rejected and the write is accepted. There is no fall-through; the record becomes readable on the next cycle.
- `overrun` clearing:
  - `clear_ovr`=1 clears `overrun`.
  - If a drop and `clear_ovr` occur in the same cycle, set wins and `overrun` stays 1.
- `RxFE`, `RxFF` and `count` are decoded from the registered `count`, so they always agree with each other.

## Timing
- Reset (asynchronous, immediate on `rst` rising):
  - `wr_ptr`=0, `rd_ptr`=0, `count`=0.
  - Outputs: `data_out`=0, `RxFE`=1, `RxFF`=0, `overrun`=0.
  - Reset asserted mid-operation discards all stored records. The first edge after deassertion behaves as normal operation.
- Write-to-visible latency: a record written at edge N raises `count` and drops `RxFE` after edge N. It can be read at edge N+1 at the earliest.
- Read latency: one cycle. With `receive` accepted at edge N, `data_out` holds the record after edge N, and `RxFE`/`count` reflect the removal after the same edge.
- Throughput: one write and one read per cycle sustained at any occupancy from 1 to `DEPTH`.
- Status outputs never glitch within a cycle, because they are derived only from registers.

## Test plan
- Reset: hold `rst`=1 mid-stream with count=5 → immediately `count`=0, `RxFE`=1, `RxFF`=0, `data_out`=0, `overrun`=0. After release, write 0x0A5 then read → `data_out`=0x0A5 one cycle after `receive`.
- Ordering and error bits: write 0x041, 0x642, 0x243 → three reads return 0x041, 0x642, 0x243 in order. `data_out[8:0]` = 0x041, 0x042, 0x043; `RxFE`=1 after the third read.
- Full and overrun:
  - Write 0x100–0x10F → `RxFF`=1, `count`=16.
  - Write 0x1FF → dropped, `overrun`=1, contents unchanged; 16 reads return 0x100–0x10F.
  - Pulse `clear_ovr` → `overrun`=0.
- Wrap-around: 40 interleaved write/read pairs with an incrementing payload → every read equals the matching write and `count` never exceeds 1. The pointers wrap twice.
- Simultaneous access:
  - At full, `wr_en`+`receive` with 0x1AA → read returns the oldest entry, `count` stays 16, and no `overrun`; 0x1AA is read last.
  - At empty, `wr_en`+`receive` → `data_out` unchanged and `count`=1.
- Empty read: `receive` pulsed while empty → `data_out`, `count` and pointers unchanged; the next write and read pair behaves normally.

Source files
------------

// File: rtl/rx_fifo_buffer.sv
// Receive-side frame FIFO: in-order 12-bit records, registered read data one cycle after an accepted receive.
// Writes arriving while full with no read in the same cycle are dropped and flagged by a sticky overrun.
module rx_fifo_buffer #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  baud_clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  receive,
    input  logic                  clear_ovr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  RxFE,
    output logic                  RxFF,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  wr_drop;

    // A read frees a slot in the same cycle, so a write at full still lands when paired with a read
    assign rd_ok   = receive && (count != '0);
    assign wr_ok   = wr_en && ((count != FULL_CNT) || rd_ok);
    assign wr_drop = wr_en && !wr_ok;

    always_ff @(posedge baud_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            overrun  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Drop has priority over clear so a coincident loss is never hidden
            if (wr_drop) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign RxFE = (count == '0);
    assign RxFF = (count == FULL_CNT);

endmodule
